extrema_tracker: RTL and testbench
==================================

# extrema_tracker

Streaming frame-extrema engine that sits in front of the serial binary comparator. It accepts a stream of unsigned words over a valid/ready handshake and drives the comparator's start/A/B. It consumes the comparator's one-cycle done pulse and flags, and tracks the running maximum and minimum with their indices. On the last word of each frame it emits one result record.

## Interface
- DATA_WIDTH, 8: operand width; must equal the comparator's DATA_WIDTH.
- COUNT_WIDTH, 8: width of word counter and indices.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_WIDTH  input word, unsigned.
- in_last  in  1  word is last of its frame.
- cmp_start  out  1  one-cycle start pulse to the comparator.
- cmp_a  out  DATA_WIDTH  comparator operand A.
- cmp_b  out  DATA_WIDTH  comparator operand B.
- cmp_agb, cmp_aeb, cmp_alb  in  1 each  comparator flags, valid only while cmp_done=1.
- cmp_done  in  1  comparator result strobe, one cycle.
- out_valid  out  1  result record valid.
- out_ready  in  1  downstream accepts the record.
- out_max, out_min  out  DATA_WIDTH  frame extrema.
- out_max_idx, out_min_idx  out  COUNT_WIDTH  zero-based index of the first occurrence.
- out_count  out  COUNT_WIDTH  words in the frame, saturating.
- out_ovf  out  1  frame exceeded 2^COUNT_WIDTH-1 words.

## Operation
- States: IDLE, MAX_GO, MAX_WAIT, MIN_GO, MIN_WAIT, EMIT.
- IDLE: in_ready=1. A handshake (in_valid&in_ready) captures in_data into the word register and in_last into the last register.
  - First word of a frame: max=min=word, both indices=0, count=1, no comparison. Go to EMIT if last, else stay in IDLE.
  - Other words: go to MAX_GO.
- MAX_GO: cmp_a=word, cmp_b=max, cmp_start=1 for exactly one cycle. Go to MAX_WAIT.
- MAX_WAIT: cmp_a and cmp_b are held stable, because the comparator reads A/B live during its compare phase. On cmp_done:
  - If cmp_agb: max=word, max_idx=index, and skip the min compare.
  - Otherwise go to MIN_GO.
- MIN_GO/MIN_WAIT: same as the max pair, with cmp_b=min. On cmp_done with cmp_alb: min=word, min_idx=index.
- After the last compare of a word: count increments. Go to EMIT if last, else IDLE.
- Tie rule: equal values never update, so the first occurrence wins.
- EMIT: out_valid=1 and in_ready=0. out_* are held stable until out_ready. On the handshake, clear the frame context and go to IDLE.
- Index of a word = count before its increment.
- out_count saturates at all-ones. out_ovf is set on the increment attempted at saturation and is sticky until the frame is emitted. Indices beyond saturation clamp to all-ones.
- cmp_done outside MAX_WAIT/MIN_WAIT is ignored, so a stray done after reset has no effect.
- Unreachable state encodings return to IDLE.

## Timing
- Reset values: in_ready=0 during reset, 1 in the first cycle after release. cmp_start=0, cmp_a=cmp_b=0, out_valid=0, all out_* = 0, state=IDLE.
- Reset mid-operation: all context is discarded on the next edge, and any pending comparator result is dropped.
- Per non-first word the block spends 1 accept cycle, then per comparison 1 (GO) + 1 (comparator idle→compare) + k (compare cycles, 1..DATA_WIDTH) + done cycle. Comparison cost is set by the comparator's latency; the block adds no stall beyond GO.
- The comparator's done coincides with its result state. The block samples the flags on that same edge and is back in IDLE, or moving on, the following cycle.
- out_valid rises the cycle after the last word's final compare, or the cycle after accepting a single-word frame's only word.
- No back-to-back accept during a compare; in_ready=0 outside IDLE.

## Structure
- Shared package extrema_pkg: the state enum (IDLE..EMIT) and the localparam for the saturation value (all-ones of COUNT_WIDTH).
- No internal sub-module. The comparator is instantiated beside this block in the parent, which converts rst_n to the comparator's active-high rst.
- The bench instantiates both.

## Test plan
- DATA_WIDTH=8, frame 3,9,9,1 with in_last on 1 → out_max=9 idx=1, out_min=1 idx=3, out_count=4, out_ovf=0.
- Single-word frame 0x5A with in_last → out_max=out_min=0x5A, indices 0, count 1, cmp_start never asserted.
- Frame 7,7,7 → max_idx=0, min_idx=0; cmp_aeb observed, no updates. Hold out_ready=0 for 5 cycles → out_* stable, in_ready=0 throughout.
- Assert rst_n=0 for one cycle while in MAX_WAIT → all outputs 0 next cycle. The following frame 4,2 gives max 4, min 2, and the late cmp_done is ignored.
- COUNT_WIDTH=2, frame of 5 words 1..5 → out_count=3, out_ovf=1, out_max=5, out_max_idx=3 (clamped).
- cmp_done pulsed in IDLE with cmp_agb=1 → no state or extrema change.

Source files
------------

// File: rtl/extrema_pkg.sv
// extrema_pkg
//   Shared types and constants for the frame-extrema engine.
//   - state_t        : control FSM states (IDLE..EMIT)
//   - COUNT_SAT_ALL  : all-ones saturation value; each instance slices the
//                      low COUNT_WIDTH bits to get its own saturation value.
package extrema_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MAX_GO   = 3'd1,
    MAX_WAIT = 3'd2,
    MIN_GO   = 3'd3,
    MIN_WAIT = 3'd4,
    EMIT     = 3'd5
  } state_t;

  localparam int unsigned   COUNT_WIDTH_MAX = 32;
  localparam logic [31:0]   COUNT_SAT_ALL   = '1;

endpackage

// File: rtl/extrema_tracker.sv
// extrema_tracker
//   Streaming frame-extrema engine. Accepts unsigned words over a
//   valid/ready handshake, uses an external serial comparator (start/A/B in,
//   done + agb/aeb/alb out) to track the running max and min of a frame with
//   the index of their first occurrence, and emits one record per frame.
//
// Ports
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   in_valid/in_ready          input handshake; in_data word, in_last ends frame
//   cmp_start/cmp_a/cmp_b      comparator request (A/B held through the compare)
//   cmp_done/cmp_agb/aeb/alb   comparator result strobe and flags
//   out_valid/out_ready        result handshake
//   out_max/out_min            frame extrema
//   out_max_idx/out_min_idx    zero-based index of first occurrence (clamped)
//   out_count/out_ovf          saturating word count and sticky overflow flag
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both 1. in_ready is 1 only in IDLE (and never during reset);
// out_valid is 1 only in EMIT, and out_* do not change until out_ready=1.
import extrema_pkg::*;

module extrema_tracker #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  output logic                   cmp_start,
  output logic [DATA_WIDTH-1:0]  cmp_a,
  output logic [DATA_WIDTH-1:0]  cmp_b,
  input  logic                   cmp_agb,
  input  logic                   cmp_aeb,
  input  logic                   cmp_alb,
  input  logic                   cmp_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_max,
  output logic [DATA_WIDTH-1:0]  out_min,
  output logic [COUNT_WIDTH-1:0] out_max_idx,
  output logic [COUNT_WIDTH-1:0] out_min_idx,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_ovf
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_SAT = COUNT_SAT_ALL[COUNT_WIDTH-1:0];
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_t                   state_q,   state_d;
  logic [DATA_WIDTH-1:0]    word_q,    word_d;
  logic                     last_q,    last_d;
  logic [DATA_WIDTH-1:0]    max_q,     max_d;
  logic [DATA_WIDTH-1:0]    min_q,     min_d;
  logic [COUNT_WIDTH-1:0]   max_idx_q, max_idx_d;
  logic [COUNT_WIDTH-1:0]   min_idx_q, min_idx_d;
  logic [COUNT_WIDTH-1:0]   count_q,   count_d;
  logic                     ovf_q,     ovf_d;

  logic                     idle_ready;
  logic                     finish_word;
  logic                     first_word;

  // count==0 with no overflow only happens before the first word of a frame,
  // because the counter saturates instead of wrapping.
  assign first_word = (count_q == '0) && !ovf_q;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    last_d      = last_q;
    max_d       = max_q;
    min_d       = min_q;
    max_idx_d   = max_idx_q;
    min_idx_d   = min_idx_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    idle_ready  = 1'b0;
    cmp_start   = 1'b0;
    cmp_a       = '0;
    cmp_b       = '0;
    out_valid   = 1'b0;
    finish_word = 1'b0;

    case (state_q)
      IDLE: begin
        idle_ready = 1'b1;
        if (in_valid) begin
          word_d = in_data;
          last_d = in_last;
          if (first_word) begin
            max_d     = in_data;
            min_d     = in_data;
            max_idx_d = '0;
            min_idx_d = '0;
            count_d   = COUNT_ONE;
            state_d   = in_last ? EMIT : IDLE;
          end else begin
            state_d = MAX_GO;
          end
        end
      end

      MAX_GO: begin
        cmp_start = 1'b1;
        cmp_a     = word_q;
        cmp_b     = max_q;
        state_d   = MAX_WAIT;
      end

      // The comparator reads A/B live while comparing, so they are held
      // here until done. A strictly-greater word replaces the max and cannot
      // also be a new min, so the min compare is skipped.
      MAX_WAIT: begin
        cmp_a = word_q;
        cmp_b = max_q;
        if (cmp_done) begin
          if (cmp_agb && !cmp_aeb) begin
            max_d       = word_q;
            max_idx_d   = count_q;
            finish_word = 1'b1;
          end else begin
            state_d = MIN_GO;
          end
        end
      end

      MIN_GO: begin
        cmp_start = 1'b1;
        cmp_a     = word_q;
        cmp_b     = min_q;
        state_d   = MIN_WAIT;
      end

      MIN_WAIT: begin
        cmp_a = word_q;
        cmp_b = min_q;
        if (cmp_done) begin
          if (cmp_alb) begin
            min_d     = word_q;
            min_idx_d = count_q;
          end
          finish_word = 1'b1;
        end
      end

      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          word_d    = '0;
          last_d    = 1'b0;
          max_d     = '0;
          min_d     = '0;
          max_idx_d = '0;
          min_idx_d = '0;
          count_d   = '0;
          ovf_d     = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Index of a word is the count before its increment; since the count
    // saturates, indices past saturation clamp to all-ones automatically.
    if (finish_word) begin
      if (count_q == COUNT_SAT) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + COUNT_ONE;
      end
      state_d = last_q ? EMIT : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      last_q    <= 1'b0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      last_q    <= last_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Never advertise ready while reset is held.
  assign in_ready    = idle_ready & rst_n;
  assign out_max     = max_q;
  assign out_min     = min_q;
  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
  assign out_count   = count_q;
  assign out_ovf     = ovf_q;

endmodule

// File: tb/tb_extrema_tracker.sv
module tb_extrema_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmp_rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cmp_k = 3;
  logic inj_done = 1'b0;
  logic inj_agb = 1'b0;

  always #5 clk = ~clk;

  // DUT 0: COUNT_WIDTH=8
  logic       in_valid0 = 0, in_ready0, in_last0 = 0, cmp_start0;
  logic [7:0] in_data0 = '0, cmp_a0, cmp_b0;
  logic       agb0, aeb0, alb0, done0, out_valid0, out_ready0 = 0, out_ovf0;
  logic [7:0] out_max0, out_min0, out_max_idx0, out_min_idx0, out_count0;

  // DUT 1: COUNT_WIDTH=2
  logic       in_valid1 = 0, in_ready1, in_last1 = 0, cmp_start1;
  logic [7:0] in_data1 = '0, cmp_a1, cmp_b1;
  logic       agb1, aeb1, alb1, done1, out_valid1, out_ready1 = 0, out_ovf1;
  logic [7:0] out_max1, out_min1;
  logic [1:0] out_max_idx1, out_min_idx1, out_count1;

  extrema_tracker #(.DATA_WIDTH(8), .COUNT_WIDTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_last(in_last0), .cmp_start(cmp_start0),
    .cmp_a(cmp_a0), .cmp_b(cmp_b0), .cmp_agb(agb0), .cmp_aeb(aeb0),
    .cmp_alb(alb0), .cmp_done(done0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_max(out_max0), .out_min(out_min0),
    .out_max_idx(out_max_idx0), .out_min_idx(out_min_idx0),
    .out_count(out_count0), .out_ovf(out_ovf0)
  );

  extrema_tracker #(.DATA_WIDTH(8), .COUNT_WIDTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_last(in_last1), .cmp_start(cmp_start1),
    .cmp_a(cmp_a1), .cmp_b(cmp_b1), .cmp_agb(agb1), .cmp_aeb(aeb1),
    .cmp_alb(alb1), .cmp_done(done1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_max(out_max1), .out_min(out_min1),
    .out_max_idx(out_max_idx1), .out_min_idx(out_min_idx1),
    .out_count(out_count1), .out_ovf(out_ovf1)
  );

  // Serial comparator models: 1 idle->compare cycle, cmp_k compare cycles,
  // then a one-cycle done with flags from the live A/B.
  int   m_ctr0 = 0, m_ctr1 = 0;
  logic m_done0 = 0, m_agb0 = 0, m_aeb0 = 0, m_alb0 = 0;
  logic m_done1 = 0, m_agb1 = 0, m_aeb1 = 0, m_alb1 = 0;

  always @(posedge clk) begin
    m_done0 <= 1'b0;
    if (!cmp_rst_n) m_ctr0 <= 0;
    else if (cmp_start0) m_ctr0 <= cmp_k + 1;
    else if (m_ctr0 != 0) begin
      m_ctr0 <= m_ctr0 - 1;
      if (m_ctr0 == 1) begin
        m_done0 <= 1'b1;
        m_agb0 <= cmp_a0 > cmp_b0; m_aeb0 <= cmp_a0 == cmp_b0; m_alb0 <= cmp_a0 < cmp_b0;
      end
    end
  end

  always @(posedge clk) begin
    m_done1 <= 1'b0;
    if (!cmp_rst_n) m_ctr1 <= 0;
    else if (cmp_start1) m_ctr1 <= cmp_k + 1;
    else if (m_ctr1 != 0) begin
      m_ctr1 <= m_ctr1 - 1;
      if (m_ctr1 == 1) begin
        m_done1 <= 1'b1;
        m_agb1 <= cmp_a1 > cmp_b1; m_aeb1 <= cmp_a1 == cmp_b1; m_alb1 <= cmp_a1 < cmp_b1;
      end
    end
  end

  assign done0 = m_done0 | inj_done;
  assign agb0  = (m_done0 & m_agb0) | (inj_done & inj_agb);
  assign aeb0  = m_done0 & m_aeb0;
  assign alb0  = m_done0 & m_alb0;
  assign done1 = m_done1;
  assign agb1  = m_done1 & m_agb1;
  assign aeb1  = m_done1 & m_aeb1;
  assign alb1  = m_done1 & m_alb1;

  int start_cnt0 = 0;
  int aeb_cnt0 = 0;
  always @(posedge clk) begin
    if (cmp_start0) start_cnt0 <= start_cnt0 + 1;
    if (done0 && aeb0) aeb_cnt0 <= aeb_cnt0 + 1;
  end

  // Driver tasks: called and return at a falling edge.
  task automatic send0(input logic [7:0] d, input logic l);
    int n = 0;
    while (!in_ready0 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready0) begin
      tests++; fails++;
      $display("FAIL send0_timeout in_ready=%b required 1", in_ready0);
    end
    in_valid0 = 1'b1; in_data0 = d; in_last0 = l;
    @(posedge clk);
    @(negedge clk);
    in_valid0 = 1'b0; in_last0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d, input logic l);
    int n = 0;
    while (!in_ready1 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready1) begin
      tests++; fails++;
      $display("FAIL send1_timeout in_ready=%b required 1", in_ready1);
    end
    in_valid1 = 1'b1; in_data1 = d; in_last1 = l;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0; in_last1 = 1'b0;
  endtask

  task automatic wait_out0(output int n);
    n = 0;
    while (!out_valid0 && n < 500) begin @(negedge clk); n++; end
    tests++;
    if (!out_valid0) begin fails++; $display("FAIL wait_out0_timeout out_valid=%b required 1", out_valid0); end
  endtask

  task automatic wait_out1(output int n);
    n = 0;
    while (!out_valid1 && n < 500) begin @(negedge clk); n++; end
    tests++;
    if (!out_valid1) begin fails++; $display("FAIL wait_out1_timeout out_valid=%b required 1", out_valid1); end
  endtask

  task automatic ack0();
    out_ready0 = 1'b1; @(posedge clk); @(negedge clk); out_ready0 = 1'b0;
  endtask

  task automatic ack1();
    out_ready1 = 1'b1; @(posedge clk); @(negedge clk); out_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmp_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (in_ready0 !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready0); end
    tests++; if (cmp_start0 !== 1'b0) begin fails++; $display("FAIL reset_cmp_start got %b want 0", cmp_start0); end
    tests++; if (cmp_a0 !== 8'd0 || cmp_b0 !== 8'd0) begin fails++; $display("FAIL reset_cmp_ab got %h/%h want 0/0", cmp_a0, cmp_b0); end
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid0); end
    tests++; if ({out_max0, out_min0, out_max_idx0, out_min_idx0, out_count0, out_ovf0} !== 41'd0) begin
      fails++; $display("FAIL reset_outs got %h want 0", {out_max0, out_min0, out_max_idx0, out_min_idx0, out_count0, out_ovf0}); end
    rst_n = 1'b1; cmp_rst_n = 1'b1;
    @(negedge clk);
    tests++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b%b want 11", in_ready0, in_ready1); end
  endtask

  task automatic test_basic_frame();
    int n;
    cmp_k = 3;
    send0(8'd3, 1'b0); send0(8'd9, 1'b0); send0(8'd9, 1'b0); send0(8'd1, 1'b1);
    wait_out0(n);
    // last word: GO + (k+2) wait, twice -> EMIT 2k+6 falling edges later
    tests++; if (n != 2 * cmp_k + 6) begin fails++; $display("FAIL basic_latency got %0d want %0d", n, 2 * cmp_k + 6); end
    tests++; if (out_max0 !== 8'd9 || out_max_idx0 !== 8'd1) begin fails++; $display("FAIL basic_max got %0d@%0d want 9@1", out_max0, out_max_idx0); end
    tests++; if (out_min0 !== 8'd1 || out_min_idx0 !== 8'd3) begin fails++; $display("FAIL basic_min got %0d@%0d want 1@3", out_min0, out_min_idx0); end
    tests++; if (out_count0 !== 8'd4 || out_ovf0 !== 1'b0) begin fails++; $display("FAIL basic_count got %0d/%b want 4/0", out_count0, out_ovf0); end
    ack0();
    tests++; if (out_valid0 !== 1'b0 || out_count0 !== 8'd0) begin fails++; $display("FAIL basic_clear got %b/%0d want 0/0", out_valid0, out_count0); end
  endtask

  task automatic test_single_word();
    int s0;
    s0 = start_cnt0;
    send0(8'h5A, 1'b1);
    tests++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL single_out_valid_next_cycle got %b want 1", out_valid0); end
    tests++; if (out_max0 !== 8'h5A || out_min0 !== 8'h5A) begin fails++; $display("FAIL single_extrema got %h/%h want 5a/5a", out_max0, out_min0); end
    tests++; if (out_max_idx0 !== 8'd0 || out_min_idx0 !== 8'd0 || out_count0 !== 8'd1) begin
      fails++; $display("FAIL single_idx_count got %0d/%0d/%0d want 0/0/1", out_max_idx0, out_min_idx0, out_count0); end
    tests++; if (start_cnt0 != s0) begin fails++; $display("FAIL single_no_start got %0d starts want 0", start_cnt0 - s0); end
    ack0();
  endtask

  task automatic test_ties_hold();
    int n, a0;
    a0 = aeb_cnt0;
    send0(8'd7, 1'b0); send0(8'd7, 1'b0); send0(8'd7, 1'b1);
    wait_out0(n);
    tests++; if (aeb_cnt0 - a0 != 4) begin fails++; $display("FAIL ties_aeb_seen got %0d want 4", aeb_cnt0 - a0); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin fails++; $display("FAIL ties_hold_hs got v=%b r=%b want v=1 r=0", out_valid0, in_ready0); end
      tests++; if (out_max0 !== 8'd7 || out_min0 !== 8'd7 || out_max_idx0 !== 8'd0 || out_min_idx0 !== 8'd0 || out_count0 !== 8'd3) begin
        fails++; $display("FAIL ties_hold_rec got %0d@%0d %0d@%0d n=%0d want 7@0 7@0 n=3", out_max0, out_max_idx0, out_min0, out_min_idx0, out_count0); end
    end
    ack0();
  endtask

  task automatic test_reset_mid();
    int n;
    cmp_k = 8;
    send0(8'd6, 1'b0); send0(8'd8, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (in_ready0 !== 1'b0 || cmp_start0 !== 1'b0 || out_valid0 !== 1'b0) begin
      fails++; $display("FAIL midreset_ctrl got r=%b s=%b v=%b want 0/0/0", in_ready0, cmp_start0, out_valid0); end
    tests++; if (cmp_a0 !== 8'd0 || cmp_b0 !== 8'd0 || out_max0 !== 8'd0 || out_min0 !== 8'd0 || out_count0 !== 8'd0) begin
      fails++; $display("FAIL midreset_data got a=%0d b=%0d max=%0d min=%0d n=%0d want 0", cmp_a0, cmp_b0, out_max0, out_min0, out_count0); end
    rst_n = 1'b1;
    n = 0;
    while (!done0 && n < 50) begin @(negedge clk); n++; end
    tests++; if (!done0) begin fails++; $display("FAIL midreset_late_done_seen got %b want 1", done0); end
    @(negedge clk);
    tests++; if (in_ready0 !== 1'b1 || cmp_start0 !== 1'b0 || out_count0 !== 8'd0) begin
      fails++; $display("FAIL midreset_late_done_ignored got r=%b s=%b n=%0d want 1/0/0", in_ready0, cmp_start0, out_count0); end
    cmp_k = 3;
    send0(8'd4, 1'b0); send0(8'd2, 1'b1);
    wait_out0(n);
    tests++; if (out_max0 !== 8'd4 || out_max_idx0 !== 8'd0 || out_min0 !== 8'd2 || out_min_idx0 !== 8'd1 || out_count0 !== 8'd2) begin
      fails++; $display("FAIL midreset_next_frame got %0d@%0d %0d@%0d n=%0d want 4@0 2@1 n=2", out_max0, out_max_idx0, out_min0, out_min_idx0, out_count0); end
    ack0();
  endtask

  task automatic test_stray_done();
    int n;
    send0(8'h10, 1'b0);
    inj_done = 1'b1; inj_agb = 1'b1;
    @(negedge clk);
    inj_done = 1'b0; inj_agb = 1'b0;
    tests++; if (in_ready0 !== 1'b1 || cmp_start0 !== 1'b0) begin fails++; $display("FAIL stray_state got r=%b s=%b want 1/0", in_ready0, cmp_start0); end
    tests++; if (out_max0 !== 8'h10 || out_max_idx0 !== 8'd0 || out_count0 !== 8'd1) begin
      fails++; $display("FAIL stray_context got %h@%0d n=%0d want 10@0 n=1", out_max0, out_max_idx0, out_count0); end
    send0(8'h08, 1'b1);
    wait_out0(n);
    tests++; if (out_max0 !== 8'h10 || out_max_idx0 !== 8'd0 || out_min0 !== 8'h08 || out_min_idx0 !== 8'd1 || out_count0 !== 8'd2) begin
      fails++; $display("FAIL stray_frame got %h@%0d %h@%0d n=%0d want 10@0 08@1 n=2", out_max0, out_max_idx0, out_min0, out_min_idx0, out_count0); end
    ack0();
  endtask

  task automatic test_saturation();
    int n;
    cmp_k = 2;
    for (int i = 1; i <= 5; i++) send1(8'(i), i == 5);
    wait_out1(n);
    tests++; if (out_count1 !== 2'd3 || out_ovf1 !== 1'b1) begin fails++; $display("FAIL sat_count got %0d/%b want 3/1", out_count1, out_ovf1); end
    tests++; if (out_max1 !== 8'd5 || out_max_idx1 !== 2'd3) begin fails++; $display("FAIL sat_max got %0d@%0d want 5@3", out_max1, out_max_idx1); end
    tests++; if (out_min1 !== 8'd1 || out_min_idx1 !== 2'd0) begin fails++; $display("FAIL sat_min got %0d@%0d want 1@0", out_min1, out_min_idx1); end
    ack1();
    tests++; if (out_ovf1 !== 1'b0 || out_count1 !== 2'd0) begin fails++; $display("FAIL sat_clear got %b/%0d want 0/0", out_ovf1, out_count1); end
  endtask

  task automatic test_back_to_back();
    int n;
    cmp_k = 1;
    send0(8'd200, 1'b0); send0(8'd50, 1'b0); send0(8'd255, 1'b0); send0(8'd0, 1'b0); send0(8'd255, 1'b1);
    wait_out0(n);
    tests++; if (out_max0 !== 8'd255 || out_max_idx0 !== 8'd2 || out_min0 !== 8'd0 || out_min_idx0 !== 8'd3 || out_count0 !== 8'd5) begin
      fails++; $display("FAIL b2b_a got %0d@%0d %0d@%0d n=%0d want 255@2 0@3 n=5", out_max0, out_max_idx0, out_min0, out_min_idx0, out_count0); end
    ack0();
    cmp_k = 8;
    send0(8'd10, 1'b0); send0(8'd20, 1'b1);
    wait_out0(n);
    tests++; if (out_max0 !== 8'd20 || out_max_idx0 !== 8'd1 || out_min0 !== 8'd10 || out_min_idx0 !== 8'd0 || out_count0 !== 8'd2) begin
      fails++; $display("FAIL b2b_b got %0d@%0d %0d@%0d n=%0d want 20@1 10@0 n=2", out_max0, out_max_idx0, out_min0, out_min_idx0, out_count0); end
    ack0();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_single_word();
    test_ties_hold();
    test_reset_mid();
    test_stray_done();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
